// File: rtl/cpu_mem_arb_pkg.sv
// Shared types and constants for the CPU instruction/data memory arbiter.
//   arb_state_e : arbiter sequencing states
//   bus_req_t   : one registered bus request (address, direction, strobes, data, id)
//   fetch_req / data_req : build a word-aligned request from CPU-side values
package cpu_mem_arb_pkg;

   typedef enum logic [2:0] {
      IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, RELEASE
   } arb_state_e;

   localparam logic        ID_INST  = 1'b0;
   localparam logic        ID_DATA  = 1'b1;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;   // addi x0,x0,0

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic        id;
   } bus_req_t;

   function automatic bus_req_t fetch_req(input logic [31:0] pc);
      bus_req_t r;
      r.addr  = {pc[31:2], 2'b00};
      r.write = 1'b0;
      r.wstrb = 4'h0;
      r.wdata = 32'h0;
      r.id    = ID_INST;
      return r;
   endfunction

   function automatic bus_req_t data_req(input logic [31:0] addr,
                                         input logic [3:0]  memrw,
                                         input logic [31:0] wdata);
      bus_req_t r;
      r.addr  = {addr[31:2], 2'b00};
      r.write = |memrw;
      r.wstrb = memrw;
      r.wdata = wdata;
      r.id    = ID_DATA;
      return r;
   endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Phase watchdog for the arbiter.
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero the count (takes priority over enable)
//   enable   : count this cycle (arbiter is in a request/wait phase)
//   expire   : this is the TIMEOUT_CYCLES-th cycle of the phase
// TIMEOUT_CYCLES = 0 disables expiry.
module arb_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);
   localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)         cnt <= '0;
      else if (clear)  cnt <= '0;
      else if (enable) cnt <= cnt + 1'b1;
   end

   // Count starts at 0 on phase entry, so cnt == N-1 marks the N-th cycle.
   assign expire = (TIMEOUT_CYCLES != 0) && enable &&
                   (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one single-outstanding memory bus between CPU fetch and data faces.
// Each pipeline advance: optional data access, then one fetch, then a
// one-cycle RELEASE where both stalls drop.
//   face_*        : CPU side (addresses, store data, byte enables, held results)
//   PCstall_axi   : high except in RELEASE
//   DMstall_axi   : high while a requested data access is pending
//   bus_req_*     : registered request channel (valid/ready)
//   bus_rsp_*     : response channel (rsp_valid also acks writes)
//   err_sticky    : error response or timeout seen since reset
module cpu_mem_arbiter
   import cpu_mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [31:0] INST_ON_ERR    = NOP_INST
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] face_pc,
   output logic [31:0] face_inst,
   input  logic [31:0] face_ALUOut,
   input  logic [31:0] face_Wdata,
   input  logic [3:0]  face_MemRW,
   input  logic        face_DMOn,
   output logic [31:0] face_Rdata,
   output logic        PCstall_axi,
   output logic        DMstall_axi,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic [31:0] bus_req_addr,
   output logic        bus_req_write,
   output logic [3:0]  bus_req_wstrb,
   output logic [31:0] bus_req_wdata,
   output logic        bus_req_id,
   input  logic        bus_rsp_valid,
   input  logic [31:0] bus_rsp_data,
   input  logic        bus_rsp_err,
   output logic        err_sticky
);

   arb_state_e  state;
   bus_req_t    req_q;
   logic        req_valid_q;
   logic        d_write_q;
   logic [31:0] pc_q;
   logic        hs, in_wait, in_phase, rsp, expire, cnt_clr;
   logic        unused_addr_lsbs;

   assign unused_addr_lsbs = ^{face_pc[1:0], face_ALUOut[1:0]};

   assign hs       = req_valid_q & bus_req_ready;
   assign in_wait  = (state == D_WAIT) || (state == I_WAIT);
   assign in_phase = in_wait || (state == D_REQ) || (state == I_REQ);
   assign rsp      = in_wait & bus_rsp_valid;
   // Any phase completion clears, so the next phase starts counting from 0.
   assign cnt_clr  = !in_phase || hs || rsp || expire;

   arb_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
      .clk    (clk),
      .rst    (rst),
      .clear  (cnt_clr),
      .enable (in_phase),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         req_q       <= '0;
         req_valid_q <= 1'b0;
         d_write_q   <= 1'b0;
         pc_q        <= '0;
         face_inst   <= '0;
         face_Rdata  <= '0;
         err_sticky  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               pc_q        <= {face_pc[31:2], 2'b00};
               d_write_q   <= |face_MemRW;
               req_valid_q <= 1'b1;
               if (face_DMOn) begin
                  req_q <= data_req(face_ALUOut, face_MemRW, face_Wdata);
                  state <= D_REQ;
               end else begin
                  req_q <= fetch_req(face_pc);
                  state <= I_REQ;
               end
            end
            D_REQ: begin
               if (hs) begin
                  req_valid_q <= 1'b0;
                  state       <= D_WAIT;
               end else if (expire) begin
                  // Valid drops for a cycle so the request never changes under valid.
                  req_valid_q <= 1'b0;
                  err_sticky  <= 1'b1;
                  if (!d_write_q) face_Rdata <= '0;
                  req_q       <= fetch_req(pc_q);
                  state       <= I_REQ;
               end
            end
            D_WAIT: begin
               if (bus_rsp_valid || expire) begin
                  // A response in the expiry cycle wins over the timeout.
                  if (!d_write_q)
                     face_Rdata <= (bus_rsp_valid && !bus_rsp_err) ? bus_rsp_data : 32'h0;
                  if (!bus_rsp_valid || bus_rsp_err) err_sticky <= 1'b1;
                  req_q       <= fetch_req(pc_q);
                  req_valid_q <= 1'b1;
                  state       <= I_REQ;
               end
            end
            I_REQ: begin
               if (!req_valid_q) begin
                  req_valid_q <= 1'b1;
               end else if (hs) begin
                  req_valid_q <= 1'b0;
                  state       <= I_WAIT;
               end else if (expire) begin
                  req_valid_q <= 1'b0;
                  err_sticky  <= 1'b1;
                  face_inst   <= INST_ON_ERR;
                  state       <= RELEASE;
               end
            end
            I_WAIT: begin
               if (bus_rsp_valid || expire) begin
                  face_inst <= (bus_rsp_valid && !bus_rsp_err) ? bus_rsp_data : INST_ON_ERR;
                  if (!bus_rsp_valid || bus_rsp_err) err_sticky <= 1'b1;
                  state     <= RELEASE;
               end
            end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign PCstall_axi   = (state != RELEASE);
   assign DMstall_axi   = (state == D_REQ) || (state == D_WAIT) ||
                          ((state == IDLE) && face_DMOn);

   assign bus_req_valid = req_valid_q;
   assign bus_req_addr  = req_q.addr;
   assign bus_req_write = req_q.write;
   assign bus_req_wstrb = req_q.wstrb;
   assign bus_req_wdata = req_q.wdata;
   assign bus_req_id    = req_q.id;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed + randomized bench for cpu_mem_arbiter. The bench plays the memory
// bus with chosen ready/response delays; expected latency and held results
// come from per-advance arithmetic on those delays.
module tb_cpu_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] face_pc, face_inst, face_ALUOut, face_Wdata, face_Rdata;
   logic [3:0]  face_MemRW;
   logic        face_DMOn, PCstall_axi, DMstall_axi;
   logic        bus_req_valid, bus_req_ready, bus_req_write, bus_req_id;
   logic [31:0] bus_req_addr, bus_req_wdata, bus_rsp_data;
   logic [3:0]  bus_req_wstrb;
   logic        bus_rsp_valid, bus_rsp_err, err_sticky;

   localparam int TMO = 8;

   cpu_mem_arbiter #(.TIMEOUT_CYCLES(TMO), .INST_ON_ERR(32'h0000_0013)) dut (
      .clk(clk), .rst(rst),
      .face_pc(face_pc), .face_inst(face_inst), .face_ALUOut(face_ALUOut),
      .face_Wdata(face_Wdata), .face_MemRW(face_MemRW), .face_DMOn(face_DMOn),
      .face_Rdata(face_Rdata), .PCstall_axi(PCstall_axi), .DMstall_axi(DMstall_axi),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
      .bus_req_addr(bus_req_addr), .bus_req_write(bus_req_write),
      .bus_req_wstrb(bus_req_wstrb), .bus_req_wdata(bus_req_wdata),
      .bus_req_id(bus_req_id), .bus_rsp_valid(bus_rsp_valid),
      .bus_rsp_data(bus_rsp_data), .bus_rsp_err(bus_rsp_err),
      .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int cyc    = 0;
   logic [31:0] m_inst, m_rdata;
   logic        m_err;

   // One pipeline advance: CPU inputs plus the bus behaviour to play.
   // rd/ri: cycles ready is held low; ld/li: idle cycles before the response
   // (>= TMO means no response at all).
   typedef struct {
      logic [31:0] pc, alu, wdata, ddata, idata;
      logic [3:0]  memrw;
      logic        dmon, derr, ierr, stray;
      int          rd, ld, ri, li;
   } adv_t;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic adv_t base(input logic [31:0] pc, input logic [31:0] idata);
      adv_t a;
      a.pc = pc; a.idata = idata; a.alu = '0; a.wdata = '0; a.ddata = '0;
      a.memrw = '0; a.dmon = 1'b0; a.derr = 1'b0; a.ierr = 1'b0; a.stray = 1'b0;
      a.rd = 0; a.ld = 0; a.ri = 0; a.li = 0;
      return a;
   endfunction

   task automatic serve_req(input string ph, input logic [31:0] ea, input logic ew,
                            input logic [3:0] es, input logic [31:0] ed, input logic eid,
                            input logic edm, input int lat);
      int g = 0;
      while (!bus_req_valid && g < 20) begin step(); g++; end
      chk({ph, "_valid"}, 32'(bus_req_valid), 32'd1);
      chk({ph, "_dmstall"}, 32'(DMstall_axi), 32'(edm));
      chk({ph, "_pcstall"}, 32'(PCstall_axi), 32'd1);
      for (int k = 0; k <= lat; k++) begin
         chk({ph, "_valid_hold"}, 32'(bus_req_valid), 32'd1);
         chk({ph, "_addr"}, bus_req_addr, ea);
         chk({ph, "_id"}, 32'(bus_req_id), 32'(eid));
         chk({ph, "_write"}, 32'(bus_req_write), 32'(ew));
         if (ew) begin
            chk({ph, "_wstrb"}, 32'(bus_req_wstrb), 32'(es));
            chk({ph, "_wdata"}, bus_req_wdata, ed);
         end
         if (k == lat) bus_req_ready = 1'b1;
         step();
      end
      bus_req_ready = 1'b0;
      // Exactly one acceptance: valid must be gone after the handshake.
      chk({ph, "_drop"}, 32'(bus_req_valid), 32'd0);
   endtask

   task automatic serve_rsp(input int lat, input logic [31:0] d, input logic e);
      if (lat < TMO) begin
         repeat (lat) step();
         bus_rsp_valid = 1'b1; bus_rsp_data = d; bus_rsp_err = e;
         step();
         bus_rsp_valid = 1'b0; bus_rsp_data = '0; bus_rsp_err = 1'b0;
      end
   endtask

   task automatic advance(input adv_t a);
      int t0, g, wd, wi, exp_cyc;
      logic dfail, ifail;
      face_pc = a.pc; face_DMOn = a.dmon; face_ALUOut = a.alu;
      face_Wdata = a.wdata; face_MemRW = a.memrw;
      if (a.stray) begin
         bus_rsp_valid = 1'b1; bus_rsp_err = 1'b1; bus_rsp_data = 32'hBAD0_BAD0;
      end
      #1;
      t0 = cyc;
      chk("idle_pcstall", 32'(PCstall_axi), 32'd1);
      chk("idle_dmstall", 32'(DMstall_axi), 32'(a.dmon));
      chk("hold_inst", face_inst, m_inst);
      chk("hold_rdata", face_Rdata, m_rdata);
      if (a.stray) begin
         step();
         bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0; bus_rsp_data = '0;
      end
      if (a.dmon) begin
         serve_req("dreq", {a.alu[31:2], 2'b00}, |a.memrw, a.memrw, a.wdata, 1'b1, 1'b1, a.rd);
         serve_rsp(a.ld, a.ddata, a.derr);
      end
      serve_req("ireq", {a.pc[31:2], 2'b00}, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, a.ri);
      serve_rsp(a.li, a.idata, a.ierr);
      g = 0;
      while (PCstall_axi && g < 40) begin step(); g++; end

      wd = (a.ld >= TMO) ? TMO : a.ld + 1;
      wi = (a.li >= TMO) ? TMO : a.li + 1;
      exp_cyc = 1 + (a.ri + 1) + wi + (a.dmon ? (a.rd + 1) + wd : 0);
      dfail = a.derr || (a.ld >= TMO);
      ifail = a.ierr || (a.li >= TMO);
      if (a.dmon) begin
         if (dfail) m_err = 1'b1;
         if (a.memrw == 4'h0) m_rdata = dfail ? 32'h0 : a.ddata;
      end
      if (ifail) begin m_err = 1'b1; m_inst = 32'h0000_0013; end
      else m_inst = a.idata;

      chk("adv_cycles", 32'(cyc - t0), 32'(exp_cyc));
      chk("release_pcstall", 32'(PCstall_axi), 32'd0);
      chk("release_dmstall", 32'(DMstall_axi), 32'd0);
      chk("face_inst", face_inst, m_inst);
      chk("face_Rdata", face_Rdata, m_rdata);
      chk("err_sticky", 32'(err_sticky), 32'(m_err));
      step();
      chk("release_one_cycle", 32'(PCstall_axi), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired checks=%0d passed=%0d", checks, passes);
      $fatal(1, "watchdog");
   end

   initial begin
      adv_t a;
      rst = 1'b1; face_pc = '0; face_ALUOut = '0; face_Wdata = '0; face_MemRW = '0;
      face_DMOn = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
      bus_rsp_data = '0; bus_rsp_err = 1'b0;
      m_inst = '0; m_rdata = '0; m_err = 1'b0;
      step(); step();
      chk("rst_valid", 32'(bus_req_valid), 32'd0);
      chk("rst_inst", face_inst, 32'h0);
      chk("rst_rdata", face_Rdata, 32'h0);
      chk("rst_err", 32'(err_sticky), 32'd0);
      chk("rst_pcstall", 32'(PCstall_axi), 32'd1);
      rst = 1'b0;

      // Fetch only, minimum latency.
      a = base(32'h0000_0100, 32'h0050_0093);
      advance(a);
      // Load then fetch, unaligned data address.
      a = base(32'h0000_0104, 32'h0000_0033);
      a.dmon = 1'b1; a.alu = 32'h0000_2006; a.ddata = 32'hDEAD_BEEF;
      advance(a);
      // Store: response is only an ack, Rdata keeps the load value.
      a = base(32'h0000_0108, 32'h0011_0113);
      a.dmon = 1'b1; a.alu = 32'h0000_3000; a.memrw = 4'b1100;
      a.wdata = 32'h1234_5678; a.ddata = 32'hFFFF_FFFF;
      advance(a);
      // Backpressure on both phases.
      a = base(32'h0000_010C, 32'h0022_0213);
      a.dmon = 1'b1; a.alu = 32'h0000_3104; a.memrw = 4'b0011;
      a.wdata = 32'hCAFE_F00D; a.rd = 5; a.ri = 5;
      advance(a);
      // Responses on the last allowed wait cycle win over the timeout.
      a = base(32'h0000_0110, 32'h00A0_0113);
      a.dmon = 1'b1; a.alu = 32'h0000_4008; a.ddata = 32'h0BAD_CAFE;
      a.ld = TMO - 1; a.li = TMO - 1;
      advance(a);
      // Fetch error response.
      a = base(32'h0000_0114, 32'h7777_7777);
      a.ierr = 1'b1;
      advance(a);
      // Fetch timeout (no response).
      a = base(32'h0000_0118, 32'h5555_5555);
      a.li = TMO + 1;
      advance(a);

      // Reset while a data read is outstanding.
      face_pc = 32'h0000_0200; face_DMOn = 1'b1; face_ALUOut = 32'h0000_4000;
      face_MemRW = 4'h0; face_Wdata = '0;
      serve_req("rstd", 32'h0000_4000, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 0);
      rst = 1'b1; face_DMOn = 1'b0;
      step();
      rst = 1'b0;
      chk("midrst_valid", 32'(bus_req_valid), 32'd0);
      chk("midrst_inst", face_inst, 32'h0);
      chk("midrst_rdata", face_Rdata, 32'h0);
      chk("midrst_err", 32'(err_sticky), 32'd0);
      chk("midrst_pcstall", 32'(PCstall_axi), 32'd1);
      m_inst = '0; m_rdata = '0; m_err = 1'b0;
      // Late response lands in IDLE and must be ignored.
      a = base(32'h0000_0300, 32'h0010_0073);
      a.stray = 1'b1;
      advance(a);

      for (int n = 0; n < 40; n++) begin
         a = base($urandom, $urandom);
         a.dmon  = 1'($urandom_range(0, 1));
         a.alu   = $urandom;
         a.wdata = $urandom;
         a.memrw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         a.ddata = $urandom;
         a.rd    = int'($urandom_range(0, 3));
         a.ri    = int'($urandom_range(0, 3));
         a.ld    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(7, 9)) : int'($urandom_range(0, 3));
         a.li    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(7, 9)) : int'($urandom_range(0, 3));
         a.derr  = ($urandom_range(0, 7) == 0);
         a.ierr  = ($urandom_range(0, 7) == 0);
         advance(a);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
